// File: rtl/apb_fll_multi_pkg.sv
// Shared types and constants for the multi-FLL APB configuration bridge.
package apb_fll_multi_pkg;

  // Handshake sequencer states; a single instance serves all FLL ports.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    ACK_LOW = 2'd2
  } fsm_state_e;

  // Page 0xF holds the bridge's own status/control registers.
  localparam logic [3:0] STATUS_PAGE = 4'hF;

  // Status register word indices (PADDR[3:2]) inside STATUS_PAGE.
  localparam logic [1:0] OFS_LOCK      = 2'd0;  // 0x0 RO
  localparam logic [1:0] OFS_LOCK_LOST = 2'd1;  // 0x4 W1C sticky
  localparam logic [1:0] OFS_IRQ_EN    = 2'd2;  // 0x8 RW
  localparam logic [1:0] OFS_ERR       = 2'd3;  // 0xC W1C

endpackage

// File: rtl/fll_sync.sv
// Reset-to-0 flop chain bringing an asynchronous FLL signal into HCLK.
module fll_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic HCLK,
  input  logic HRESETn,
  input  logic i_d,
  output logic o_q
);

  logic [SYNC_STAGES-1:0] r_chain;

  // Shift the asynchronous input through SYNC_STAGES flops.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_chain <= {SYNC_STAGES{1'b0}};
    end else begin
      r_chain <= {r_chain[SYNC_STAGES-2:0], i_d};
    end
  end

  assign o_q = r_chain[SYNC_STAGES-1];

endmodule

// File: rtl/apb_fll_if_multi.sv
// APB bridge turning accesses to FLL register pages into four-phase
// req/ack handshakes, with ack timeout, lock-loss tracking and an interrupt.
module apb_fll_if_multi
  import apb_fll_multi_pkg::*;
#(
  parameter int APB_ADDR_WIDTH = 12,
  parameter int NB_FLL         = 3,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                      HCLK,
  input  logic                      HRESETn,
  input  logic [APB_ADDR_WIDTH-1:0] PADDR,
  input  logic [31:0]               PWDATA,
  input  logic                      PWRITE,
  input  logic                      PSEL,
  input  logic                      PENABLE,
  output logic [31:0]               PRDATA,
  output logic                      PREADY,
  output logic                      PSLVERR,
  output logic [NB_FLL-1:0]         fll_req,
  output logic [NB_FLL-1:0]         fll_wrn,
  output logic [NB_FLL*2-1:0]       fll_add,
  output logic [NB_FLL*32-1:0]      fll_data,
  input  logic [NB_FLL-1:0]         fll_ack,
  input  logic [NB_FLL*32-1:0]      fll_r_data,
  input  logic [NB_FLL-1:0]         fll_lock,
  output logic                      irq_o
);

  localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]       NB_PAGES = 4'(NB_FLL);

  if (NB_FLL < 1 || NB_FLL > 15 || SYNC_STAGES < 2 || TIMEOUT_CYCLES < 4 ||
      APB_ADDR_WIDTH < 9) begin : g_bad_param
    $error("apb_fll_if_multi: illegal parameter value");
  end

  fsm_state_e                r_state, w_state_nxt;
  logic [3:0]                r_sel;
  logic                      r_rd;
  logic [CNT_W-1:0]          r_cnt;
  logic [NB_FLL-1:0]         r_req, r_wrn;
  logic [NB_FLL-1:0][1:0]    r_add;
  logic [NB_FLL-1:0][31:0]   r_data;
  logic [NB_FLL-1:0]         r_lock_prev, r_lock_lost, r_irq_en, r_err;
  logic                      r_irq;

  logic [NB_FLL-1:0]         w_ack_sync, w_lock_sync, w_sel_onehot;
  logic [NB_FLL-1:0]         w_ll_clr, w_err_clr, w_err_set, w_lock_fall;
  logic [3:0]                w_page;
  logic [1:0]                w_reg;
  logic                      w_access, w_is_fll, w_is_status;
  logic                      w_ack_page, w_ack_cur;
  logic [31:0]               w_rdata_cur, w_status_rdata;
  logic                      w_start, w_done, w_timeout, w_status_wr;
  logic [APB_ADDR_WIDTH-7:0] w_unused_paddr;

  for (genvar g = 0; g < NB_FLL; g++) begin : g_sync
    fll_sync #(.SYNC_STAGES(SYNC_STAGES)) u_ack_sync (
      .HCLK(HCLK), .HRESETn(HRESETn), .i_d(fll_ack[g]), .o_q(w_ack_sync[g]));
    fll_sync #(.SYNC_STAGES(SYNC_STAGES)) u_lock_sync (
      .HCLK(HCLK), .HRESETn(HRESETn), .i_d(fll_lock[g]), .o_q(w_lock_sync[g]));
  end

  assign w_page         = PADDR[7:4];
  assign w_reg          = PADDR[3:2];
  assign w_access       = PSEL & PENABLE;
  assign w_is_fll       = (w_page < NB_PAGES);
  assign w_is_status    = (w_page == STATUS_PAGE);
  assign w_unused_paddr = {PADDR[APB_ADDR_WIDTH-1:8], PADDR[1:0]};
  assign w_lock_fall    = r_lock_prev & ~w_lock_sync;
  assign w_err_set      = w_sel_onehot & {NB_FLL{w_timeout}};

  // Pick the ack/read data of the addressed page and of the active port.
  always_comb begin
    w_ack_page   = 1'b0;
    w_ack_cur    = 1'b0;
    w_rdata_cur  = 32'h0;
    w_sel_onehot = {NB_FLL{1'b0}};
    for (int i = 0; i < NB_FLL; i++) begin
      w_sel_onehot[i] = (4'(i) == r_sel);
      w_ack_page      = w_ack_page | (w_ack_sync[i] & (4'(i) == w_page));
      w_ack_cur       = w_ack_cur  | (w_ack_sync[i] & (4'(i) == r_sel));
      w_rdata_cur     = w_rdata_cur | (fll_r_data[i*32 +: 32] & {32{4'(i) == r_sel}});
    end
  end

  // Status page read mux and W1C clear masks.
  always_comb begin
    w_ll_clr  = {NB_FLL{1'b0}};
    w_err_clr = {NB_FLL{1'b0}};
    case (w_reg)
      OFS_LOCK:      w_status_rdata = 32'(w_lock_sync);
      OFS_LOCK_LOST: w_status_rdata = 32'(r_lock_lost);
      OFS_IRQ_EN:    w_status_rdata = 32'(r_irq_en);
      OFS_ERR:       w_status_rdata = 32'(r_err);
      default:       w_status_rdata = 32'h0;
    endcase
    if (w_status_wr && (w_reg == OFS_LOCK_LOST)) begin
      w_ll_clr = PWDATA[NB_FLL-1:0];
    end else if (w_status_wr && (w_reg == OFS_ERR)) begin
      w_err_clr = PWDATA[NB_FLL-1:0];
    end else begin
      w_ll_clr  = {NB_FLL{1'b0}};
      w_err_clr = {NB_FLL{1'b0}};
    end
  end

  // Sequencer next state and APB response.
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_done      = 1'b0;
    w_timeout   = 1'b0;
    w_status_wr = 1'b0;
    PREADY      = 1'b0;
    PSLVERR     = 1'b0;
    PRDATA      = 32'h0;
    case (r_state)
      IDLE: begin
        if (w_access && w_is_fll) begin
          // A stale ack from the previous handshake holds the access off.
          if (!w_ack_page) begin
            w_start     = 1'b1;
            w_state_nxt = REQ;
          end else begin
            w_state_nxt = IDLE;
          end
        end else if (w_access) begin
          PREADY      = 1'b1;
          w_status_wr = PWRITE & w_is_status;
          if (!PWRITE && w_is_status) begin
            PRDATA = w_status_rdata;
          end else begin
            PRDATA = 32'h0;
          end
        end else begin
          w_state_nxt = IDLE;
        end
      end
      REQ: begin
        if (w_ack_cur) begin
          PREADY      = 1'b1;
          PRDATA      = r_rd ? w_rdata_cur : 32'h0;
          w_done      = 1'b1;
          w_state_nxt = ACK_LOW;
        end else if (r_cnt == CNT_LAST) begin
          PREADY      = 1'b1;
          PSLVERR     = 1'b1;
          w_done      = 1'b1;
          w_timeout   = 1'b1;
          w_state_nxt = ACK_LOW;
        end else begin
          w_state_nxt = REQ;
        end
      end
      ACK_LOW: begin
        if (!w_ack_cur) begin
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = ACK_LOW;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Sequencer state register.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FLL port registers and timeout counter; ports idle at wrn=1/add=0/data=0.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_sel  <= 4'h0;
      r_rd   <= 1'b0;
      r_cnt  <= {CNT_W{1'b0}};
      r_req  <= {NB_FLL{1'b0}};
      r_wrn  <= {NB_FLL{1'b1}};
      r_add  <= {NB_FLL{2'b00}};
      r_data <= {NB_FLL{32'h0}};
    end else if (w_start) begin
      r_sel <= w_page;
      r_rd  <= ~PWRITE;
      r_cnt <= {CNT_W{1'b0}};
      for (int i = 0; i < NB_FLL; i++) begin
        if (4'(i) == w_page) begin
          r_req[i]  <= 1'b1;
          r_wrn[i]  <= ~PWRITE;
          r_add[i]  <= w_reg;
          r_data[i] <= PWDATA;
        end
      end
    end else if (w_done) begin
      r_req  <= {NB_FLL{1'b0}};
      r_wrn  <= {NB_FLL{1'b1}};
      r_add  <= {NB_FLL{2'b00}};
      r_data <= {NB_FLL{32'h0}};
    end else if (r_state == REQ) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Status registers: a set in the same cycle as a W1C clear wins.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_lock_prev <= {NB_FLL{1'b0}};
      r_lock_lost <= {NB_FLL{1'b0}};
      r_irq_en    <= {NB_FLL{1'b0}};
      r_err       <= {NB_FLL{1'b0}};
      r_irq       <= 1'b0;
    end else begin
      r_lock_prev <= w_lock_sync;
      r_lock_lost <= (r_lock_lost & ~w_ll_clr) | w_lock_fall;
      r_err       <= (r_err & ~w_err_clr) | w_err_set;
      r_irq       <= |(r_lock_lost & r_irq_en);
      if (w_status_wr && (w_reg == OFS_IRQ_EN)) begin
        r_irq_en <= PWDATA[NB_FLL-1:0];
      end
    end
  end

  assign fll_req  = r_req;
  assign fll_wrn  = r_wrn;
  assign fll_add  = r_add;
  assign fll_data = r_data;
  assign irq_o    = r_irq;

endmodule

// File: tb/tb_apb_fll_if_multi.sv
// Self-checking bench for apb_fll_if_multi (3 FLLs, 2 sync stages, 16-cycle timeout).
module tb_apb_fll_if_multi;

  localparam int NB = 3;

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b1;
  logic [11:0] PADDR = 12'h0;
  logic [31:0] PWDATA = 32'h0;
  logic        PWRITE = 1'b0, PSEL = 1'b0, PENABLE = 1'b0;
  logic [31:0] PRDATA;
  logic        PREADY, PSLVERR, irq_o;
  logic [2:0]  fll_req, fll_wrn;
  logic [5:0]  fll_add;
  logic [95:0] fll_data;
  wire  [2:0]  fll_ack;
  wire  [95:0] fll_r_data;
  logic [2:0]  fll_lock = 3'b111;

  int          n_cmp = 0;
  int          n_fail = 0;
  int unsigned dly[3];
  int unsigned low_dly[3];
  logic        en[3];
  logic [31:0] rd_cfg[3];

  typedef struct {
    logic [11:0] addr;
    logic [31:0] wdata;
    logic        wr;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_cyc;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
    logic        fll;
    logic [1:0]  add;
    logic        wrn;
    logic [31:0] data;
  } exp_t;

  exp_t sb_q[$];
  vec_t tbl[14];

  apb_fll_if_multi #(
    .APB_ADDR_WIDTH(12), .NB_FLL(NB), .SYNC_STAGES(2), .TIMEOUT_CYCLES(16)
  ) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .PADDR(PADDR), .PWDATA(PWDATA),
    .PWRITE(PWRITE), .PSEL(PSEL), .PENABLE(PENABLE), .PRDATA(PRDATA),
    .PREADY(PREADY), .PSLVERR(PSLVERR), .fll_req(fll_req), .fll_wrn(fll_wrn),
    .fll_add(fll_add), .fll_data(fll_data), .fll_ack(fll_ack),
    .fll_r_data(fll_r_data), .fll_lock(fll_lock), .irq_o(irq_o)
  );

  always #5 HCLK = ~HCLK;

  // Behavioural FLL responders, clocked on the falling edge.
  for (genvar g = 0; g < NB; g++) begin : g_resp
    logic        ack_l = 1'b0;
    logic [31:0] data_l = 32'h0;
    assign fll_ack[g]              = ack_l;
    assign fll_r_data[g*32 +: 32]  = data_l;
    initial begin
      forever begin
        @(negedge HCLK);
        if (fll_req[g] && en[g]) begin
          repeat (dly[g]) @(negedge HCLK);
          ack_l  = 1'b1;
          data_l = rd_cfg[g];
          do @(negedge HCLK); while (fll_req[g]);
          repeat (low_dly[g]) @(negedge HCLK);
          ack_l  = 1'b0;
          data_l = 32'h0;
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge HCLK);
  endtask

  task automatic apb_xfer(input logic [11:0] addr, input logic [31:0] wdata, input logic wr,
                          output logic [31:0] rdata, output logic err, output int cyc,
                          output logic seen, output logic [1:0] oadd, output logic owrn,
                          output logic [31:0] odata);
    int  pg;
    logic got;
    pg = int'(addr[7:4]);
    got = 1'b0; seen = 1'b0; oadd = 2'b00; owrn = 1'b1; odata = 32'h0;
    rdata = 32'h0; err = 1'b0; cyc = 0;
    @(posedge HCLK); #1;
    PADDR = addr; PWDATA = wdata; PWRITE = wr; PSEL = 1'b1; PENABLE = 1'b0;
    @(posedge HCLK); #1;
    PENABLE = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(negedge HCLK);
      cyc++;
      if (fll_req != 3'b000) seen = 1'b1;
      if (pg < NB && fll_req[pg]) begin
        oadd  = fll_add[pg*2 +: 2];
        owrn  = fll_wrn[pg];
        odata = fll_data[pg*32 +: 32];
      end
      if (PREADY) begin
        rdata = PRDATA; err = PSLVERR; got = 1'b1;
        break;
      end
    end
    if (!got) check("apb_ready_bound", {31'h0, PREADY}, 32'h1);
    @(posedge HCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    exp_t        e;
    logic [31:0] rd, od;
    logic        er, seen, ow;
    logic [1:0]  oa;
    int          cyc;
    e.rdata = v.exp_rdata; e.err = v.exp_err; e.cyc = v.exp_cyc;
    e.fll = (v.addr[7:4] < 4'd3); e.add = v.addr[3:2]; e.wrn = ~v.wr; e.data = v.wdata;
    sb_q.push_back(e);
    apb_xfer(v.addr, v.wdata, v.wr, rd, er, cyc, seen, oa, ow, od);
    e = sb_q.pop_front();
    check($sformatf("prdata@%h", v.addr), rd, e.rdata);
    check($sformatf("pslverr@%h", v.addr), {31'h0, er}, {31'h0, e.err});
    check($sformatf("cycles@%h", v.addr), 32'(cyc), 32'(e.cyc));
    check($sformatf("req_seen@%h", v.addr), {31'h0, seen}, {31'h0, e.fll});
    if (e.fll) begin
      check($sformatf("fll_add@%h", v.addr), {30'h0, oa}, {30'h0, e.add});
      check($sformatf("fll_wrn@%h", v.addr), {31'h0, ow}, {31'h0, e.wrn});
      check($sformatf("fll_data@%h", v.addr), od, e.data);
    end
  endtask

  initial begin
    int cyc;
    en[0] = 1'b0; en[1] = 1'b1; en[2] = 1'b1;
    dly[0] = 0; dly[1] = 3; dly[2] = 0;
    low_dly[0] = 0; low_dly[1] = 0; low_dly[2] = 0;
    rd_cfg[0] = 32'h0; rd_cfg[1] = 32'hCAFEF00D; rd_cfg[2] = 32'h12345678;

    tbl[0]  = '{12'h0F0, 32'h0,        1'b0, 32'h7,        1'b0, 1};
    tbl[1]  = '{12'h0F8, 32'hFFFFFFFC, 1'b1, 32'h0,        1'b0, 1};
    tbl[2]  = '{12'h0F8, 32'h0,        1'b0, 32'h4,        1'b0, 1};
    tbl[3]  = '{12'h0FC, 32'h0,        1'b0, 32'h0,        1'b0, 1};
    tbl[4]  = '{12'h0F4, 32'h0,        1'b0, 32'h0,        1'b0, 1};
    tbl[5]  = '{12'h0A0, 32'h0,        1'b0, 32'h0,        1'b0, 1};
    tbl[6]  = '{12'h0A4, 32'hFFFFFFFF, 1'b1, 32'h0,        1'b0, 1};
    tbl[7]  = '{12'h0A4, 32'h0,        1'b0, 32'h0,        1'b0, 1};
    tbl[8]  = '{12'h018, 32'h0,        1'b0, 32'hCAFEF00D, 1'b0, 7};
    tbl[9]  = '{12'h020, 32'h55AA55AA, 1'b1, 32'h0,        1'b0, 4};
    tbl[10] = '{12'h02C, 32'h0,        1'b0, 32'h12345678, 1'b0, 4};
    tbl[11] = '{12'h030, 32'h0,        1'b0, 32'h0,        1'b0, 1};
    tbl[12] = '{12'h0E8, 32'hFFFFFFFF, 1'b1, 32'h0,        1'b0, 1};
    tbl[13] = '{12'h0F8, 32'h0,        1'b0, 32'h4,        1'b0, 1};

    // Reset values while HRESETn is low.
    #2 HRESETn = 1'b0;
    #2;
    check("rst_req",  {29'h0, fll_req}, 32'h0);
    check("rst_wrn",  {29'h0, fll_wrn}, 32'h7);
    check("rst_add",  {26'h0, fll_add}, 32'h0);
    check("rst_data", fll_data[31:0] | fll_data[63:32] | fll_data[95:64], 32'h0);
    check("rst_irq",  {31'h0, irq_o}, 32'h0);
    repeat (3) @(negedge HCLK);
    HRESETn = 1'b1;
    idle(5);

    // Write 0xDEADBEEF to FLL1 reg 1, FLL acks 3 cycles after req.
    @(posedge HCLK); #1;
    PADDR = 12'h014; PWDATA = 32'hDEADBEEF; PWRITE = 1'b1; PSEL = 1'b1; PENABLE = 1'b0;
    @(posedge HCLK); #1;
    PENABLE = 1'b1;
    @(negedge HCLK); cyc = 1;
    check("s1_req_c1", {29'h0, fll_req}, 32'h0);
    @(negedge HCLK); cyc = 2;
    check("s1_req_c2", {29'h0, fll_req}, 32'h2);
    check("s1_add",    {26'h0, fll_add}, 32'h4);
    check("s1_wrn",    {29'h0, fll_wrn}, 32'h5);
    check("s1_data",   fll_data[63:32], 32'hDEADBEEF);
    check("s1_data_other", fll_data[31:0] | fll_data[95:64], 32'h0);
    while (!PREADY && cyc < 50) begin
      @(negedge HCLK); cyc++;
      check("s1_data_hold", fll_data[63:32], 32'hDEADBEEF);
    end
    check("s1_cycles",  32'(cyc), 32'd7);
    check("s1_pslverr", {31'h0, PSLVERR}, 32'h0);
    @(posedge HCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
    @(negedge HCLK);
    check("s1_req_drop", {29'h0, fll_req}, 32'h0);
    check("s1_wrn_idle", {29'h0, fll_wrn}, 32'h7);
    check("s1_add_idle", {26'h0, fll_add}, 32'h0);
    check("s1_data_idle", fll_data[63:32], 32'h0);
    idle(6);

    // Table of single accesses through the scoreboard.
    for (int i = 0; i < 14; i++) begin
      run_vec(tbl[i]);
      idle(6);
    end

    // Back-to-back read while FLL2 still holds ack: second access stalls.
    low_dly[2] = 6;
    run_vec('{12'h028, 32'h0, 1'b0, 32'h12345678, 1'b0, 4});
    run_vec('{12'h024, 32'h0, 1'b0, 32'h12345678, 1'b0, 11});
    low_dly[2] = 0;
    idle(6);

    // FLL0 never acks: timeout, ERR set, then W1C clear.
    run_vec('{12'h000, 32'h1, 1'b1, 32'h0, 1'b1, 17});
    check("to_req_low", {29'h0, fll_req}, 32'h0);
    idle(4);
    run_vec('{12'h0FC, 32'h0, 1'b0, 32'h1, 1'b0, 1});
    run_vec('{12'h0FC, 32'h1, 1'b1, 32'h0, 1'b0, 1});
    run_vec('{12'h0FC, 32'h0, 1'b0, 32'h0, 1'b0, 1});
    idle(4);

    // Lock loss on FLL2 with IRQ_EN = 0x4.
    @(negedge HCLK); fll_lock[2] = 1'b0;
    repeat (3) @(negedge HCLK);
    check("irq_before", {31'h0, irq_o}, 32'h0);
    @(negedge HCLK);
    check("irq_after", {31'h0, irq_o}, 32'h1);
    run_vec('{12'h0F4, 32'h0, 1'b0, 32'h4, 1'b0, 1});
    run_vec('{12'h0F0, 32'h0, 1'b0, 32'h3, 1'b0, 1});
    fll_lock[2] = 1'b1;
    idle(5);

    // W1C of LOCK_LOST in the very cycle a new fall is detected.
    @(posedge HCLK); #1;
    @(negedge HCLK); fll_lock[2] = 1'b0;
    @(posedge HCLK); #1;
    PADDR = 12'h0F4; PWDATA = 32'h4; PWRITE = 1'b1; PSEL = 1'b1; PENABLE = 1'b0;
    @(posedge HCLK); #1;
    PENABLE = 1'b1;
    @(negedge HCLK);
    check("w1c_race_ready", {31'h0, PREADY}, 32'h1);
    @(posedge HCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
    run_vec('{12'h0F4, 32'h0, 1'b0, 32'h4, 1'b0, 1});
    check("irq_held", {31'h0, irq_o}, 32'h1);
    run_vec('{12'h0F4, 32'h4, 1'b1, 32'h0, 1'b0, 1});
    run_vec('{12'h0F4, 32'h0, 1'b0, 32'h0, 1'b0, 1});
    idle(3);
    check("irq_cleared", {31'h0, irq_o}, 32'h0);
    fll_lock[2] = 1'b1;
    idle(5);

    // Reset asserted while FLL0 is in REQ.
    @(posedge HCLK); #1;
    PADDR = 12'h004; PWDATA = 32'h77; PWRITE = 1'b1; PSEL = 1'b1; PENABLE = 1'b0;
    @(posedge HCLK); #1;
    PENABLE = 1'b1;
    repeat (3) @(negedge HCLK);
    check("rst_mid_req_pre", {29'h0, fll_req}, 32'h1);
    #2 HRESETn = 1'b0;
    #1;
    check("rst_mid_req", {29'h0, fll_req}, 32'h0);
    check("rst_mid_wrn", {29'h0, fll_wrn}, 32'h7);
    PSEL = 1'b0; PENABLE = 1'b0;
    @(negedge HCLK); HRESETn = 1'b1;
    idle(5);
    run_vec('{12'h01C, 32'hA5A5A5A5, 1'b1, 32'h0, 1'b0, 7});
    idle(6);
    run_vec('{12'h0FC, 32'h0, 1'b0, 32'h0, 1'b0, 1});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/apb_fll_if_multi.md
Name: apb_fll_if_multi

Overview:
Parametrised APB-to-FLL configuration bridge for NB_FLL independent FLLs. Each FLL uses an asynchronous four-phase req/ack port.
- Converts each APB access to an FLL register page into one handshake on the selected FLL.
- Adds an ack timeout with PSLVERR, lock-loss detection, and a maskable interrupt.
- Sits on the SoC peripheral APB in the HCLK domain, next to the clock-generation macros.

Parameters:
APB_ADDR_WIDTH, 12, APB address width; only PADDR[7:2] is decoded.
NB_FLL, 3, number of FLL ports, legal range 1..15; elaboration assertion otherwise.
SYNC_STAGES, 2, synchroniser depth for ack and lock, minimum 2.
TIMEOUT_CYCLES, 1024, HCLK cycles in REQ before an access is aborted; minimum 4.

Ports:
HCLK  in  1  clock
HRESETn  in  1  asynchronous active-low reset
PADDR  in  APB_ADDR_WIDTH  APB address
PWDATA  in  32  APB write data
PWRITE  in  1  APB direction, 1 = write
PSEL  in  1  APB select
PENABLE  in  1  APB enable
PRDATA  out  32  APB read data
PREADY  out  1  APB ready
PSLVERR  out  1  APB error
fll_req  out  NB_FLL  per-FLL request, registered
fll_wrn  out  NB_FLL  per-FLL 1 = read, 0 = write, registered
fll_add  out  NB_FLL*2  per-FLL register index (PADDR[3:2]), registered
fll_data  out  NB_FLL*32  per-FLL write data, registered
fll_ack  in  NB_FLL  per-FLL ack, asynchronous
fll_r_data  in  NB_FLL*32  per-FLL read data, valid while ack is high
fll_lock  in  NB_FLL  per-FLL lock, asynchronous
irq_o  out  1  lock-lost interrupt, registered

Behaviour:
Reset: HRESETn is asynchronous, active-low; clock is HCLK. All values below are entered immediately on reset:
- fll_req = 0, fll_wrn = all 1, fll_add = 0, fll_data = 0, irq_o = 0.
- LOCK_LOST = 0, IRQ_EN = 0, ERR = 0, FSM = IDLE, timeout counter = 0.
- A reset in the middle of a handshake drops req asynchronously.

Address decode: page = PADDR[7:4], reg = PADDR[3:2].
- Page i < NB_FLL: FLL i register reg, accessed through a handshake.
- Page 0xF status registers:
  - 0x0 LOCK (RO): bits[NB_FLL-1:0] = synchronised lock.
  - 0x4 LOCK_LOST (W1C, sticky): bit set on a 1->0 edge of synchronised lock.
  - 0x8 IRQ_EN (RW): bits[NB_FLL-1:0].
  - 0xC ERR (W1C): bit set on timeout of that FLL.
  - Unused bits read 0.
- Page 0xF and unmapped pages: PREADY = 1 in the first PENABLE cycle, PSLVERR = 0. Unmapped reads return 0; unmapped writes are ignored.
- Set and W1C clear in the same cycle: set wins.

FSM (one shared instance; only one FLL is active at a time):
- IDLE: on PSEL & PENABLE to page k < NB_FLL with ack_sync[k] = 0:
  - load fll_wrn[k] = ~PWRITE, fll_add[k] = PADDR[3:2], fll_data[k] = PWDATA;
  - set fll_req[k] = 1, clear counter, go to REQ.
  - If ack_sync[k] = 1 (stale ack), stay in IDLE with PREADY = 0.
- REQ: hold req, wrn, add and data stable; increment counter.
  - ack_sync[k] = 1: PREADY = 1 this cycle; PRDATA = fll_r_data[k] on a read, 0 on a write; req drops next cycle; go to ACK_LOW.
  - Else, counter = TIMEOUT_CYCLES-1: PREADY = 1, PSLVERR = 1, PRDATA = 0, set ERR[k], drop req, go to ACK_LOW.
- ACK_LOW: req = 0. Go to IDLE when ack_sync[k] = 0. Any new APB access waits with PREADY = 0.
- Unselected ports, and the selected port outside REQ: wrn = 1, add = 0, data = 0.
- Latency, no CDC delay: 1 cycle to assert req, SYNC_STAGES cycles for ack, giving PREADY on the 2+SYNC_STAGES-th PENABLE cycle.

Interrupt: irq_o <= |(LOCK_LOST & IRQ_EN), one cycle after the register update.

Decomposition:
- Package apb_fll_multi_pkg: FSM state enum {IDLE, REQ, ACK_LOW}; STATUS_PAGE = 4'hF; offset constants LOCK/LOCK_LOST/IRQ_EN/ERR.
- Sub-module fll_sync: a SYNC_STAGES-deep reset-to-0 flop chain, instantiated 2*NB_FLL times (ack and lock).

Test Plan:
- Write 0xDEADBEEF to 0x014, FLL1 acks after 3 cycles -> fll_req[1] rises 1 cycle after PENABLE; fll_add[1] = 1; fll_wrn[1] = 0; fll_data[1] = 0xDEADBEEF stable until ack; PREADY after 2+SYNC_STAGES+3 cycles; PSLVERR = 0.
- Read 0x028, FLL2 returns 0x12345678 -> PRDATA = 0x12345678 in the PREADY cycle. A second access issued while ack is still high stalls until ack_sync falls.
- FLL0 never acks, TIMEOUT_CYCLES = 16 -> PREADY = 1 and PSLVERR = 1 in REQ cycle 16; ERR = 0x1; req low. Writing 1 to 0xFC clears ERR.
- lock[2] goes 1->0 with IRQ_EN = 0x4 -> LOCK_LOST = 0x4 after SYNC_STAGES+1 cycles; irq_o = 1 one cycle later. W1C on the same cycle as a new fall -> bit stays set.
- Read 0x0F0 / 0x0A0 (unmapped, NB_FLL = 3) -> zero-wait PREADY. 0x0F0 returns the lock vector; 0x0A0 returns 0; no req is issued.
- HRESETn asserted in REQ -> fll_req = 0 immediately, FSM = IDLE; the next access completes normally.
